pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Hazard and stall sequencer for the 5-stage pipelined CPU. It generates the PC write-enable and stall controls, the IF/ID write/flush controls and the ID/EX bubble control. It detects load-use hazards, flushes on taken branches, and runs a data-cache miss FSM that freezes the whole pipeline while the refill handshake with data memory completes.

Parameters:
REG_W, 5, register-index width
CNT_W, 32, width of stall performance counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  CPU run enable; low = hold fetch
id_rs_i  in  REG_W  rs index of instruction in ID
id_rt_i  in  REG_W  rt index of instruction in ID
id_use_rt_i  in  1  ID instruction reads rt
ex_memread_i  in  1  EX instruction is a load
ex_rt_i  in  REG_W  destination rt of EX load
id_branch_taken_i  in  1  branch/jump resolved taken in ID
mem_miss_i  in  1  MEM-stage access missed in data cache
mem_ack_i  in  1  data memory refill complete (1-cycle pulse)
pcwrite_o  out  1  PC write enable
stall_o  out  1  global freeze (PC and all pipeline registers)
ifid_write_o  out  1  IF/ID register write enable
ifid_flush_o  out  1  IF/ID clear to NOP
idex_bubble_o  out  1  ID/EX control fields zeroed
mem_req_o  out  1  refill request to data memory
stall_cycles_o  out  CNT_W  stall cycle counter (see Optional Feature)

Behaviour:
- Reset, rst_i=1 at a clock edge: FSM -> IDLE and counter -> 0. While rst_i=1, all outputs are forced combinationally to 0. This includes mem_req_o even if the FSM is mid-MISS.
- Load-use hazard, combinational: hz = ex_memread_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_use_rt_i && ex_rt_i==id_rt_i)).
- Memory FSM states: IDLE, MISS, REFILL.
  - IDLE: mem_miss_i=1 -> MISS.
  - MISS: mem_ack_i=1 -> REFILL, else stay.
  - REFILL: always -> IDLE after 1 cycle.
- Freeze, combinational: stall_o = (state==IDLE && mem_miss_i) || state==MISS || state==REFILL.
- mem_req_o = 1 exactly while state==MISS.
- If mem_ack_i arrives in IDLE or REFILL, it is ignored.
- Minimum miss penalty: ack in the first MISS cycle gives stall_o high for 3 cycles.
- Output priority, highest first:
  1. stall_o=1: pcwrite_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0. The pipeline is frozen, with no bubble and no flush.
  2. hz=1: pcwrite_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0. A branch taken in the same cycle is suppressed because its operands are not ready and it re-resolves next cycle.
  3. id_branch_taken_i=1: ifid_flush_o=1, pcwrite_o=1, ifid_write_o=1.
  4. Otherwise: pcwrite_o=1, ifid_write_o=1, flush=0, bubble=0.
- start_i=0: pcwrite_o=0 and ifid_write_o=0 regardless of the above. The FSM still runs, so an in-flight refill completes.
- All control outputs except mem_req_o are combinational, with zero latency. Only state and the counter are registered.

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- When defined: stall_cycles_o increments by 1 on every clock with rst_i=0 and (stall_o || hz). It saturates at all-ones and clears on reset.
- When undefined: the counter logic is absent and stall_cycles_o is tied to 0.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, MISS=2'd1, REFILL=2'd2), REG_W default, zero-register constant.
- One natural sub-module: hazard_detect, which contains the combinational load-use compare producing hz.
- The FSM, priority logic and counter stay in pipe_stall_ctrl.

Test Plan:
- Load-use: ex_memread_i=1, ex_rt_i=8, id_rs_i=8 -> pcwrite_o=0, ifid_write_o=0, idex_bubble_o=1 for that cycle. With ex_rt_i=0 -> no hazard.
- Branch: id_branch_taken_i=1, no hazard -> ifid_flush_o=1, pcwrite_o=1. Branch combined with hazard -> flush=0, bubble=1.
- Cache miss: mem_miss_i=1 at cycle 0, mem_ack_i at cycle 4 -> stall_o=1 for cycles 0-5, mem_req_o=1 for cycles 1-4, stall_o=0 at cycle 6.
- Miss combined with load-use in the same cycle -> stall_o=1, idex_bubble_o=0. The bubble appears only after the freeze releases, if hz still holds.
- Reset mid-MISS: rst_i=1 at cycle 2 of a miss -> mem_req_o=0 immediately, state IDLE next cycle, stray mem_ack_i ignored.
- Perf counter (macro on): 3-cycle miss plus 1 load-use -> stall_cycles_o=4. Preload the counter near all-ones -> it saturates and does not wrap.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
// Optional stall counter is enabled by PIPE_STALL_PERF_EN.
package pipe_stall_ctrl_pkg;

    localparam int unsigned REG_W_DEF = 5;
    localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MISS   = 2'd1,
        ST_REFILL = 2'd2
    } mem_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the EX load and the ID instruction.
// Register 0 is hard-wired, so a load targeting it never creates a hazard.
module hazard_detect
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rt_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    output logic             hz_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt_i == id_rs_i);
    assign rt_match = id_use_rt_i && (ex_rt_i == id_rt_i);
    assign hz_o     = ex_memread_i && (ex_rt_i != REG_W'(ZERO_REG)) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall sequencer: load-use bubbles, branch flushes, data-cache miss freeze.
// Define PIPE_STALL_PERF_EN to build the saturating stall-cycle counter.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rt_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             id_branch_taken_i,
    input  logic             mem_miss_i,
    input  logic             mem_ack_i,
    output logic             pcwrite_o,
    output logic             stall_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             mem_req_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    mem_state_e state_q;
    logic       hz;
    logic       freeze;

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard_detect (
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_use_rt_i  (id_use_rt_i),
        .ex_memread_i (ex_memread_i),
        .ex_rt_i      (ex_rt_i),
        .hz_o         (hz)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (mem_miss_i) state_q <= ST_MISS;
                ST_MISS:   if (mem_ack_i)  state_q <= ST_REFILL;
                ST_REFILL: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // The freeze starts in the very cycle the miss is reported, before the FSM leaves IDLE.
    assign freeze = ((state_q == ST_IDLE) && mem_miss_i) ||
                    (state_q == ST_MISS) || (state_q == ST_REFILL);

    always_comb begin
        pcwrite_o     = 1'b0;
        stall_o       = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        mem_req_o     = 1'b0;
        if (!rst_i) begin
            stall_o   = freeze;
            mem_req_o = (state_q == ST_MISS);
            if (freeze) begin
                pcwrite_o    = 1'b0;
            end else if (hz) begin
                idex_bubble_o = 1'b1;
            end else if (id_branch_taken_i) begin
                ifid_flush_o = 1'b1;
                pcwrite_o    = 1'b1;
                ifid_write_o = 1'b1;
            end else begin
                pcwrite_o    = 1'b1;
                ifid_write_o = 1'b1;
            end
            if (!start_i) begin
                pcwrite_o    = 1'b0;
                ifid_write_o = 1'b0;
            end
        end
    end

`ifdef PIPE_STALL_PERF_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if ((freeze || hz) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles_o = rst_i ? '0 : cnt_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl: vector table plus miss/reset sequences.
module tb_pipe_stall_ctrl;
    import pipe_stall_ctrl_pkg::*;

    localparam int unsigned TB_REG_W = 5;
    localparam int unsigned TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [TB_REG_W-1:0] id_rs, id_rt, ex_rt;
    logic                id_use_rt, ex_memread, br_taken, mem_miss, mem_ack;
    logic                pcwrite, stall, ifid_write, ifid_flush, idex_bubble, mem_req;
    logic [TB_CNT_W-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .REG_W(TB_REG_W),
        .CNT_W(TB_CNT_W)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_use_rt_i       (id_use_rt),
        .ex_memread_i      (ex_memread),
        .ex_rt_i           (ex_rt),
        .id_branch_taken_i (br_taken),
        .mem_miss_i        (mem_miss),
        .mem_ack_i         (mem_ack),
        .pcwrite_o         (pcwrite),
        .stall_o           (stall),
        .ifid_write_o      (ifid_write),
        .ifid_flush_o      (ifid_flush),
        .idex_bubble_o     (idex_bubble),
        .mem_req_o         (mem_req),
        .stall_cycles_o    (stall_cycles)
    );

    typedef struct {
        logic       start;
        logic [4:0] rs, rt;
        logic       use_rt, memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       e_pcw, e_ifw, e_flush, e_bub;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs as {pcwrite, ifid_write, ifid_flush, idex_bubble, stall, mem_req}
    task automatic chk_out(input string name, input logic [5:0] exp);
        chk(name, {26'd0, pcwrite, ifid_write, ifid_flush, idex_bubble, stall, mem_req}, {26'd0, exp});
    endtask

    task automatic quiet_inputs();
        start = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_use_rt = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0; br_taken = 1'b0;
        mem_miss = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic set_hz(input logic on);
        ex_memread = on; ex_rt = 5'd8; id_rs = 5'd8;
    endtask

    // Drive at the falling edge, settle, then let the caller check before the rising edge.
    task automatic drive(input logic r, input logic miss, input logic ack);
        @(negedge clk);
        rst = r; mem_miss = miss; mem_ack = ack;
        #1;
    endtask

    initial begin
        vecs[0]  = '{1, 5'd8, 5'd2, 0, 1, 5'd8, 0,  0, 0, 0, 1};
        vecs[1]  = '{1, 5'd0, 5'd0, 1, 1, 5'd0, 0,  1, 1, 0, 0};
        vecs[2]  = '{1, 5'd3, 5'd8, 1, 1, 5'd8, 0,  0, 0, 0, 1};
        vecs[3]  = '{1, 5'd3, 5'd8, 0, 1, 5'd8, 0,  1, 1, 0, 0};
        vecs[4]  = '{1, 5'd8, 5'd2, 0, 0, 5'd8, 0,  1, 1, 0, 0};
        vecs[5]  = '{1, 5'd4, 5'd5, 1, 1, 5'd6, 1,  1, 1, 1, 0};
        vecs[6]  = '{1, 5'd8, 5'd2, 0, 1, 5'd8, 1,  0, 0, 0, 1};
        vecs[7]  = '{0, 5'd4, 5'd5, 0, 0, 5'd6, 0,  0, 0, 0, 0};
        vecs[8]  = '{0, 5'd4, 5'd5, 0, 0, 5'd6, 1,  0, 0, 1, 0};
        vecs[9]  = '{0, 5'd8, 5'd2, 0, 1, 5'd8, 0,  0, 0, 0, 1};
        vecs[10] = '{1, 5'd31, 5'd2, 0, 1, 5'd31, 0, 0, 0, 0, 1};

        quiet_inputs();
        rst = 1'b1;
        drive(1, 0, 0);
        chk_out("reset_outputs", 6'b000000);
        chk("reset_counter", 32'(stall_cycles), 32'd0);
        drive(0, 0, 0);
        chk_out("idle_after_reset", 6'b110000);

        foreach (vecs[i]) begin
            @(negedge clk);
            start = vecs[i].start; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_use_rt = vecs[i].use_rt; ex_memread = vecs[i].memread;
            ex_rt = vecs[i].ex_rt; br_taken = vecs[i].br;
            #1;
            chk_out($sformatf("vec%0d", i),
                    {vecs[i].e_pcw, vecs[i].e_ifw, vecs[i].e_flush, vecs[i].e_bub, 2'b00});
        end
        quiet_inputs();

        // Miss at cycle 0, ack at cycle 4: stall 0..5, mem_req 1..4, released at 6.
        for (int c = 0; c <= 6; c++) begin
            drive(0, c == 0, c == 4);
            chk_out($sformatf("miss_c%0d", c),
                    (c <= 5) ? {4'b0000, 1'b1, (c >= 1 && c <= 4)} : 6'b110000);
        end

        // Stray ack in IDLE must not start anything.
        drive(0, 0, 1);
        chk_out("stray_ack_idle", 6'b110000);
        drive(0, 0, 0);
        chk_out("stray_ack_after", 6'b110000);

        // Miss together with load-use: freeze wins, bubble only once released.
        set_hz(1);
        drive(0, 1, 0);
        chk_out("miss_hz_c0", 6'b000010);
        drive(0, 0, 1);
        chk_out("miss_hz_c1", 6'b000011);
        drive(0, 0, 0);
        chk_out("miss_hz_refill", 6'b000010);
        drive(0, 0, 0);
        chk_out("miss_hz_release", 6'b000100);
        quiet_inputs();

        // start low during a miss: refill still completes.
        start = 1'b0;
        drive(0, 1, 0);
        chk_out("nostart_miss", 6'b000010);
        drive(0, 0, 1);
        chk_out("nostart_req", 6'b000011);
        drive(0, 0, 0);
        chk_out("nostart_refill", 6'b000010);
        drive(0, 0, 0);
        chk_out("nostart_idle", 6'b000000);
        start = 1'b1;

        // Reset in the second MISS cycle.
        drive(0, 1, 0);
        chk_out("rstmiss_c0", 6'b000010);
        drive(0, 0, 0);
        chk_out("rstmiss_c1", 6'b000011);
        drive(1, 0, 0);
        chk_out("rstmiss_c2_rst", 6'b000000);
        drive(0, 0, 1);
        chk_out("rstmiss_c3_ack", 6'b110000);
        drive(0, 0, 0);
        chk_out("rstmiss_c4", 6'b110000);

        // Minimum miss penalty (ack in first MISS cycle) plus one load-use cycle.
        drive(1, 0, 0);
        drive(0, 1, 0);
        chk_out("minpen_c0", 6'b000010);
        drive(0, 0, 1);
        chk_out("minpen_c1", 6'b000011);
        drive(0, 0, 0);
        chk_out("minpen_c2", 6'b000010);
        set_hz(1);
        drive(0, 0, 0);
        chk_out("minpen_hz", 6'b000100);
        quiet_inputs();
        drive(0, 0, 0);
        chk_out("minpen_done", 6'b110000);
`ifdef PIPE_STALL_PERF_EN
        chk("perf_count4", 32'(stall_cycles), 32'd4);
`else
        chk("perf_absent", 32'(stall_cycles), 32'd0);
`endif

        // Long miss drives the counter into saturation.
        drive(0, 1, 0);
        for (int c = 0; c < 20; c++) drive(0, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk_out("long_miss_done", 6'b110000);
`ifdef PIPE_STALL_PERF_EN
        chk("perf_saturate", 32'(stall_cycles), 32'd15);
`else
        chk("perf_absent_long", 32'(stall_cycles), 32'd0);
`endif
        drive(1, 0, 0);
        chk("counter_cleared", 32'(stall_cycles), 32'd0);
        drive(0, 0, 0);
        chk("counter_after_rst", 32'(stall_cycles), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
